// File: rtl/h14tx_period_sequencer_pkg.sv
// h14tx_period_sequencer_pkg: period encoding, HDMI 1.4 period lengths and CTL preamble codes
package h14tx_period_sequencer_pkg;
  typedef enum logic [2:0] {
    CTRL,
    VID_PRE,
    VID_GUARD,
    VIDEO,
    ISL_PRE,
    ISL_LGUARD,
    ISL_DATA,
    ISL_TGUARD
  } period_t;
  localparam int PreambleLen = 8;
  localparam int GuardLen = 2;
  localparam int PacketLen = 32;
  localparam int LookAhead = PreambleLen + GuardLen + 1;
  localparam logic [3:0] CtlVideo = 4'b0001;
  localparam logic [3:0] CtlIsland = 4'b0101;
  // blanking an island of n packets consumes, plus the trailing control gap and look-ahead
  function automatic logic [15:0] isl_need(input logic [4:0] n, input int min_ctrl);
    return 16'(PreambleLen + 2 * GuardLen + PacketLen * int'(n) + min_ctrl + LookAhead);
  endfunction
endpackage

// File: rtl/h14tx_period_sequencer_delay_line.sv
// h14tx_delay_line: fixed-depth shift register with asynchronous clear
module h14tx_delay_line #(
  parameter int Width = 1,
  parameter int Depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_data
);
  logic [Depth-1:0][Width-1:0] r_sr;
  // shift one stage per clock, newest sample in stage 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sr <= '0;
    else r_sr <= {r_sr[Depth-2:0], i_data};
  assign o_data = r_sr[Depth-1];
endmodule

// File: rtl/h14tx_period_sequencer.sv
// h14tx_period_sequencer: schedules video/data-island periods, preambles and guard bands ahead of delayed timing
module h14tx_period_sequencer
  import h14tx_period_sequencer_pkg::*;
#(
  parameter int MaxPackets = 18,
  parameter int MinCtrl = 12,
  parameter int BlankW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic [BlankW-1:0] blank_left_i,
  input  logic              isl_valid_i,
  input  logic [4:0]        isl_packets_i,
  output logic              isl_ack_o,
  output logic              isl_err_o,
  output logic              isl_abort_o,
  output logic              pkt_start_o,
  output period_t           period_o,
  output logic [3:0]        ctl_o,
  output logic              guard_switch_o,
  output logic              de_o,
  output logic              hsync_o,
  output logic              vsync_o
);
  localparam logic [3:0] PreLast = 4'(PreambleLen - 1);
  localparam logic [3:0] GuardLast = 4'(GuardLen - 1);
  logic [2:0] w_dly;
  logic       r_de_prev;
  logic [3:0] r_ctrl_cnt;
  logic [3:0] r_phase;
  logic [4:0] r_off;
  logic [4:0] r_pcnt;
  logic [4:0] r_npk;
  period_t    w_nxt;
  logic       w_rise;
  logic       w_legal;
  logic       w_room;
  logic       w_ctrl_ok;
  logic       w_in_isl;
  logic       w_pg;
  logic       w_start;
  logic       w_err;
  logic       w_abort;
  // the final output register stage lives here, so w_dly is the next cycle's delayed timing
  h14tx_delay_line #(
    .Width(3),
    .Depth(LookAhead - 1)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_data({de_i, hsync_i, vsync_i}),
    .o_data(w_dly)
  );
  assign w_rise    = de_i & ~r_de_prev;
  assign w_legal   = (isl_packets_i != 5'd0) && (isl_packets_i <= 5'(MaxPackets));
  assign w_room    = 16'(blank_left_i) >= isl_need(isl_packets_i, MinCtrl);
  assign w_ctrl_ok = r_ctrl_cnt >= 4'(MinCtrl);
  assign w_in_isl  = period_o inside {ISL_PRE, ISL_LGUARD, ISL_DATA, ISL_TGUARD};
  assign w_pg      = w_nxt inside {VID_PRE, VID_GUARD, ISL_PRE, ISL_LGUARD, ISL_TGUARD};
  // next period; a raw de rise always wins over island start or island continuation
  always_comb begin
    w_nxt = period_o;
    w_start = 1'b0;
    w_err = 1'b0;
    w_abort = 1'b0;
    case (period_o)
      CTRL:
        if (w_rise) w_nxt = VID_PRE;
        else if (isl_valid_i && !w_legal) w_err = 1'b1;
        else if (isl_valid_i && w_ctrl_ok && w_room) begin
          w_nxt = ISL_PRE;
          w_start = 1'b1;
        end
      VID_PRE:    w_nxt = (r_phase == PreLast) ? VID_GUARD : VID_PRE;
      VID_GUARD:  w_nxt = (r_phase == GuardLast) ? VIDEO : VID_GUARD;
      VIDEO:      w_nxt = w_dly[2] ? VIDEO : CTRL;
      ISL_PRE:    w_nxt = (r_phase == PreLast) ? ISL_LGUARD : ISL_PRE;
      ISL_LGUARD: w_nxt = (r_phase == GuardLast) ? ISL_DATA : ISL_LGUARD;
      ISL_DATA:   w_nxt = (r_off == 5'd31 && r_pcnt == r_npk - 5'd1) ? ISL_TGUARD : ISL_DATA;
      ISL_TGUARD: w_nxt = (r_phase == GuardLast) ? CTRL : ISL_TGUARD;
      default:    w_nxt = CTRL;
    endcase
    if (w_in_isl && w_rise) begin
      w_nxt = VID_PRE;
      w_abort = 1'b1;
    end
  end
  // registered outputs, all derived from the next period so they stay aligned with period_o
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      period_o <= CTRL;
      isl_ack_o <= 1'b0;
      isl_err_o <= 1'b0;
      isl_abort_o <= 1'b0;
      pkt_start_o <= 1'b0;
      ctl_o <= 4'b0;
      guard_switch_o <= 1'b0;
      {de_o, hsync_o, vsync_o} <= 3'b0;
    end else begin
      period_o <= w_nxt;
      isl_ack_o <= w_start;
      isl_err_o <= w_err;
      isl_abort_o <= w_abort;
      pkt_start_o <= (w_nxt == ISL_DATA) && (period_o != ISL_DATA || r_off == 5'd31);
      ctl_o <= (w_nxt == VID_PRE) ? CtlVideo : (w_nxt == ISL_PRE) ? CtlIsland : 4'b0;
      guard_switch_o <= w_nxt inside {ISL_LGUARD, ISL_TGUARD};
      {de_o, hsync_o, vsync_o} <= w_dly;
    end
  // period counters: control gap, preamble/guard phase, packet offset and packet count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_de_prev <= 1'b0;
      r_ctrl_cnt <= 4'd0;
      r_phase <= 4'd0;
      r_off <= 5'd0;
      r_pcnt <= 5'd0;
      r_npk <= 5'd0;
    end else begin
      r_de_prev <= de_i;
      r_ctrl_cnt <= (period_o != CTRL) ? 4'd0 : w_ctrl_ok ? r_ctrl_cnt : r_ctrl_cnt + 4'd1;
      r_phase <= (w_nxt != period_o || !w_pg) ? 4'd0 : r_phase + 4'd1;
      r_off <= (w_nxt != ISL_DATA || period_o != ISL_DATA) ? 5'd0 : r_off + 5'd1;
      r_pcnt <= (w_nxt != ISL_DATA || period_o != ISL_DATA) ? 5'd0 : r_pcnt + {4'b0, r_off == 5'd31};
      r_npk <= w_start ? isl_packets_i : r_npk;
    end
endmodule

// File: tb/tb_h14tx_period_sequencer.sv
// tb_h14tx_period_sequencer: directed table and sequence checks of period scheduling
module tb_h14tx_period_sequencer;
  import h14tx_period_sequencer_pkg::*;
  typedef struct {
    logic [4:0]  n;
    logic [11:0] blank;
    logic        ack;
    logic        err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic de_i = 1'b0;
  logic hsync_i = 1'b0;
  logic vsync_i = 1'b0;
  logic [11:0] blank_left_i = 12'd0;
  logic isl_valid_i = 1'b0;
  logic [4:0] isl_packets_i = 5'd0;
  logic isl_ack_o, isl_err_o, isl_abort_o, pkt_start_o, guard_switch_o, de_o, hsync_o, vsync_o;
  logic [3:0] ctl_o;
  period_t period_o;
  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[9];
  always #5 clk = ~clk;
  h14tx_period_sequencer dut (
    .clk(clk), .rst_n(rst_n), .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .blank_left_i(blank_left_i), .isl_valid_i(isl_valid_i), .isl_packets_i(isl_packets_i),
    .isl_ack_o(isl_ack_o), .isl_err_o(isl_err_o), .isl_abort_o(isl_abort_o),
    .pkt_start_o(pkt_start_o), .period_o(period_o), .ctl_o(ctl_o),
    .guard_switch_o(guard_switch_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic wait_ctrl();
    int k = 0;
    while (period_o != CTRL && k < 2000) begin
      tick();
      k++;
    end
    check("wait_ctrl", 32'(period_o), 32'(CTRL));
  endtask
  task automatic request(input logic [4:0] n, input logic [11:0] blank);
    isl_packets_i = n;
    blank_left_i = blank;
    isl_valid_i = 1'b1;
  endtask
  // expected {period, ctl, guard_switch, pkt_start, ack} at cycle a after an accepted n-packet request
  function automatic logic [9:0] isl_exp(input int a, input int n);
    period_t p;
    if (a < 8) p = ISL_PRE;
    else if (a < 10) p = ISL_LGUARD;
    else if (a < 10 + 32 * n) p = ISL_DATA;
    else if (a < 12 + 32 * n) p = ISL_TGUARD;
    else p = CTRL;
    return {p, (a < 8) ? 4'b0101 : 4'b0000, p == ISL_LGUARD || p == ISL_TGUARD,
            p == ISL_DATA && (a - 10) % 32 == 0, a == 0};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{5'd0, 12'd500, 1'b0, 1'b1};
    tbl[1] = '{5'd19, 12'd700, 1'b0, 1'b1};
    tbl[2] = '{5'd31, 12'd4000, 1'b0, 1'b1};
    tbl[3] = '{5'd1, 12'd67, 1'b1, 1'b0};
    tbl[4] = '{5'd1, 12'd66, 1'b0, 1'b0};
    tbl[5] = '{5'd18, 12'd611, 1'b1, 1'b0};
    tbl[6] = '{5'd18, 12'd610, 1'b0, 1'b0};
    tbl[7] = '{5'd2, 12'd200, 1'b1, 1'b0};
    tbl[8] = '{5'd18, 12'd4095, 1'b1, 1'b0};
    idle(3);
    check("reset_state", 32'({period_o, ctl_o, guard_switch_o, pkt_start_o, isl_ack_o, isl_err_o, isl_abort_o, de_o}), 32'(0));
    rst_n = 1'b1;
    idle(15);
    // video preamble/guard timing, hsync delay
    de_i = 1'b1;
    hsync_i = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      hsync_i = 1'b0;
      check($sformatf("vid_k%0d", k), 32'({period_o, ctl_o, guard_switch_o, de_o, hsync_o}),
            32'({(k <= 8) ? VID_PRE : (k <= 10) ? VID_GUARD : VIDEO, (k <= 8) ? 4'b0001 : 4'b0000, 1'b0, k == 11, k == 11}));
    end
    request(5'd2, 12'd200);
    idle(5);
    check("no_ack_in_video", 32'(isl_ack_o), 32'(0));
    de_i = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      tick();
      check($sformatf("vid_end_j%0d", j), 32'({period_o, de_o, isl_ack_o}),
            32'({(j == 11) ? CTRL : VIDEO, j < 11, 1'b0}));
    end
    for (int k = 1; k <= 13; k++) begin
      tick();
      check($sformatf("ctrl_gap_k%0d", k), 32'(isl_ack_o), 32'(k == 13));
    end
    isl_valid_i = 1'b0;
    for (int a = 0; a <= 76; a++) begin
      if (a > 0) tick();
      check($sformatf("isl2_a%0d", a), 32'({period_o, ctl_o, guard_switch_o, pkt_start_o, isl_ack_o}), 32'(isl_exp(a, 2)));
    end
    // table of single-cycle requests after a full control gap
    for (int i = 0; i < 9; i++) begin
      idle(13);
      request(tbl[i].n, tbl[i].blank);
      tick();
      isl_valid_i = 1'b0;
      check($sformatf("tbl%0d", i), 32'({isl_ack_o, isl_err_o, period_o}),
            32'({tbl[i].ack, tbl[i].err, tbl[i].ack ? ISL_PRE : CTRL}));
      tick();
      check($sformatf("tbl%0d_pulse", i), 32'({isl_ack_o, isl_err_o}), 32'(0));
      if (tbl[i].ack) wait_ctrl();
    end
    // held request gets acked once blanking is large enough
    idle(13);
    request(5'd4, 12'd150);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("held_k%0d", k), 32'({isl_ack_o, period_o}), 32'({1'b0, CTRL}));
    end
    blank_left_i = 12'd300;
    tick();
    isl_valid_i = 1'b0;
    check("held_ack", 32'({isl_ack_o, period_o}), 32'({1'b1, ISL_PRE}));
    wait_ctrl();
    // video rise in the middle of island data
    idle(13);
    request(5'd3, 12'd400);
    tick();
    isl_valid_i = 1'b0;
    check("abort_ack", 32'(isl_ack_o), 32'(1));
    idle(20);
    check("abort_in_data", 32'(period_o), 32'(ISL_DATA));
    de_i = 1'b1;
    tick();
    check("abort_pulse", 32'({isl_abort_o, period_o, ctl_o}), 32'({1'b1, VID_PRE, 4'b0001}));
    tick();
    check("abort_once", 32'(isl_abort_o), 32'(0));
    idle(7);
    check("abort_vguard1", 32'({period_o, guard_switch_o}), 32'({VID_GUARD, 1'b0}));
    tick();
    check("abort_vguard2", 32'({period_o, guard_switch_o}), 32'({VID_GUARD, 1'b0}));
    de_i = 1'b0;
    wait_ctrl();
    // simultaneous de rise and start condition
    idle(13);
    request(5'd1, 12'd200);
    de_i = 1'b1;
    tick();
    isl_valid_i = 1'b0;
    check("simul_rise", 32'({isl_ack_o, isl_err_o, period_o}), 32'({2'b00, VID_PRE}));
    idle(3);
    de_i = 1'b0;
    wait_ctrl();
    // asynchronous reset mid-island, request still valid
    idle(13);
    request(5'd2, 12'd200);
    tick();
    check("rst_ack", 32'(isl_ack_o), 32'(1));
    idle(15);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'({period_o, ctl_o, guard_switch_o, pkt_start_o, isl_ack_o, isl_abort_o}), 32'(0));
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      check($sformatf("rst_gap_k%0d", k), 32'({isl_ack_o, isl_abort_o}), 32'({k == 13, 1'b0}));
    end
    isl_valid_i = 1'b0;
    wait_ctrl();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
